nr_div_sched: RTL and testbench

Two-requester scheduler that shares one `NR_Div` Newton-Raphson divider between Paillier datapath clients, e.g. the L-function `(x-1)/n` units of two decrypt lanes. It arbitrates round-robin and issues the divider start pulse. It forwards the owner's block-serial operand stream, padding the divisor with zero blocks, and routes the quotient blocks back to the owner. A watchdog aborts and resets the divider if the quotient never completes.

---
 rtl/nr_div_sched.sv | 152 +++++++++++++++
 tb/tb_nr_div_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nr_div_sched.sv
// rtl/nr_div_sched.sv - round-robin scheduler sharing one NR divider between two requesters
module nr_div_sched #(
    parameter int N       = 4096,
    parameter int M       = 2048,
    parameter int Block   = 128,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_0,
    input  logic             req_1,
    output logic             gnt_0,
    output logic             gnt_1,
    input  logic             blk_vld_0,
    input  logic             blk_vld_1,
    input  logic [Block-1:0] dividend_blk_0,
    input  logic [Block-1:0] dividend_blk_1,
    input  logic [Block-1:0] divisor_blk_0,
    input  logic [Block-1:0] divisor_blk_1,
    output logic [Block-1:0] q_blk_o,
    output logic             q_vld_0,
    output logic             q_vld_1,
    output logic             done_0,
    output logic             done_1,
    output logic             err_0,
    output logic             err_1,
    output logic             div_valid_in,
    output logic             div_data_vld_in,
    output logic [Block-1:0] div_dividend_in,
    output logic [Block-1:0] div_divisor_in,
    input  logic [Block-1:0] div_quotient_out,
    input  logic             div_data_vld_out,
    output logic             div_rst_n
);
    localparam int NB = N / Block;
    localparam int MB = M / Block;
    localparam int IW = $clog2(NB) + 1;
    localparam int OW = $clog2(MB) + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [IW-1:0] IN_LAST  = IW'(NB - 1);
    localparam logic [IW-1:0] DIVS_END = IW'(MB);
    localparam logic [OW-1:0] OUT_LAST = OW'(MB - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_LOAD, S_WAIT, S_DONE, S_ABORT
    } state_t;

    state_t          state;
    logic            owner;
    logic            prio;
    logic [IW-1:0]   in_cnt;
    logic [OW-1:0]   out_cnt;
    logic [WW-1:0]   wdog;

    logic             pick;
    logic             own_vld;
    logic [Block-1:0] own_dividend;
    logic [Block-1:0] own_divisor;

    // Priority only matters when both requesters compete for the same IDLE cycle.
    assign pick         = (req_0 && req_1) ? prio : req_1;
    assign own_vld      = owner ? blk_vld_1 : blk_vld_0;
    assign own_dividend = owner ? dividend_blk_1 : dividend_blk_0;
    assign own_divisor  = owner ? divisor_blk_1 : divisor_blk_0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            owner           <= 1'b0;
            prio            <= 1'b0;
            in_cnt          <= '0;
            out_cnt         <= '0;
            wdog            <= '0;
            gnt_0           <= 1'b0;
            gnt_1           <= 1'b0;
            q_blk_o         <= '0;
            q_vld_0         <= 1'b0;
            q_vld_1         <= 1'b0;
            done_0          <= 1'b0;
            done_1          <= 1'b0;
            err_0           <= 1'b0;
            err_1           <= 1'b0;
            div_valid_in    <= 1'b0;
            div_data_vld_in <= 1'b0;
            div_dividend_in <= '0;
            div_divisor_in  <= '0;
            div_rst_n       <= 1'b0;
        end else begin
            div_valid_in    <= 1'b0;
            div_data_vld_in <= 1'b0;
            q_vld_0         <= 1'b0;
            q_vld_1         <= 1'b0;
            done_0          <= 1'b0;
            done_1          <= 1'b0;
            err_0           <= 1'b0;
            err_1           <= 1'b0;
            div_rst_n       <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (req_0 || req_1) begin
                        owner        <= pick;
                        gnt_0        <= ~pick;
                        gnt_1        <= pick;
                        div_valid_in <= 1'b1;
                        in_cnt       <= '0;
                        out_cnt      <= '0;
                        wdog         <= '0;
                        state        <= S_START;
                    end
                end
                S_START: state <= S_LOAD;
                S_LOAD: begin
                    if (own_vld) begin
                        div_data_vld_in <= 1'b1;
                        div_dividend_in <= own_dividend;
                        // The divisor is shorter than the dividend; zero-pad its tail beats.
                        div_divisor_in  <= (in_cnt < DIVS_END) ? own_divisor : '0;
                        in_cnt          <= in_cnt + 1'b1;
                        if (in_cnt == IN_LAST) state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (div_data_vld_out) begin
                        q_blk_o <= div_quotient_out;
                        q_vld_0 <= ~owner;
                        q_vld_1 <= owner;
                        out_cnt <= out_cnt + 1'b1;
                    end
                    if (div_data_vld_out && out_cnt == OUT_LAST) begin
                        done_0 <= ~owner;
                        done_1 <= owner;
                        state  <= S_DONE;
                    end else if (wdog == WD_LAST) begin
                        err_0     <= ~owner;
                        err_1     <= owner;
                        div_rst_n <= 1'b0;
                        state     <= S_ABORT;
                    end
                end
                S_DONE, S_ABORT: begin
                    gnt_0 <= 1'b0;
                    gnt_1 <= 1'b0;
                    prio  <= ~owner;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nr_div_sched.sv
// tb/tb_nr_div_sched.sv - randomized self-checking bench for nr_div_sched with a divider model
module tb_nr_div_sched;
    localparam int N  = 4096;
    localparam int M  = 2048;
    localparam int B  = 128;
    localparam int NB = N / B;
    localparam int MB = M / B;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]   req, gnt, blk_vld, q_vld, done, err;
    logic [B-1:0] dividend_blk [2];
    logic [B-1:0] divisor_blk  [2];
    logic [B-1:0] q_blk;
    logic         div_valid_in, div_data_vld_in, div_data_vld_out, div_rst_n;
    logic [B-1:0] div_dividend_in, div_divisor_in, div_quotient_out;

    nr_div_sched #(.N(N), .M(M), .Block(B), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_0(req[0]), .req_1(req[1]), .gnt_0(gnt[0]), .gnt_1(gnt[1]),
        .blk_vld_0(blk_vld[0]), .blk_vld_1(blk_vld[1]),
        .dividend_blk_0(dividend_blk[0]), .dividend_blk_1(dividend_blk[1]),
        .divisor_blk_0(divisor_blk[0]), .divisor_blk_1(divisor_blk[1]),
        .q_blk_o(q_blk), .q_vld_0(q_vld[0]), .q_vld_1(q_vld[1]),
        .done_0(done[0]), .done_1(done[1]), .err_0(err[0]), .err_1(err[1]),
        .div_valid_in(div_valid_in), .div_data_vld_in(div_data_vld_in),
        .div_dividend_in(div_dividend_in), .div_divisor_in(div_divisor_in),
        .div_quotient_out(div_quotient_out), .div_data_vld_out(div_data_vld_out),
        .div_rst_n(div_rst_n)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester operands and per-lane observations
    logic [N-1:0] lx [2];
    logic [M-1:0] ld [2];
    logic [M-1:0] qacc [2];
    int idx [2], gcnt [2], gap_at [2], gap_len [2];
    int qcnt [2], done_beat [2], done_cyc [2], err_cyc [2], gnt_rise [2], gnt_fall [2];
    int done_cnt [2], err_cnt [2];
    logic [1:0] in_load = '0, gnt_q = '0;
    int qtotal = 0;

    always @(negedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (gnt[r] && !gnt_q[r]) begin
                gnt_rise[r] = cyc; qcnt[r] = 0; qacc[r] = '0; done_beat[r] = 0;
            end
            if (!gnt[r] && gnt_q[r]) gnt_fall[r] = cyc;
            if (!gnt[r]) begin
                idx[r] = 0; gcnt[r] = 0; blk_vld[r] = 1'b0; in_load[r] = 1'b0;
            end else if (!in_load[r]) begin
                in_load[r] = 1'b1; blk_vld[r] = 1'b0;
            end else begin
                if (blk_vld[r]) idx[r]++;
                if (idx[r] == gap_at[r] && gcnt[r] < gap_len[r]) begin
                    gcnt[r]++; blk_vld[r] = 1'b0;
                end else if (idx[r] < NB) begin
                    blk_vld[r] = 1'b1;
                    dividend_blk[r] = lx[r][(NB-1-idx[r])*B +: B];
                    divisor_blk[r] = (idx[r] < MB) ? ld[r][(MB-1-idx[r])*B +: B]
                                     : {$urandom, $urandom, $urandom, $urandom};
                end else blk_vld[r] = 1'b0;
            end
            if (q_vld[r]) begin
                qtotal++;
                if (qcnt[r] < MB) qacc[r][qcnt[r]*B +: B] = q_blk;
                qcnt[r]++;
                if (done[r]) done_beat[r] = qcnt[r];
            end
            if (done[r]) begin done_cnt[r]++; done_cyc[r] = cyc; end
            if (err[r]) begin err_cnt[r]++; err_cyc[r] = cyc; end
        end
        gnt_q = gnt;
    end

    // Divider stand-in: collects the forwarded operands, divides, streams the quotient LSB block first
    logic [N-1:0] mx, mq;
    logic [M-1:0] md;
    int mphase = 0, mcnt = 0, mlat = 0, memit = 0;
    bit skipped = 0;
    int starts = 0, beats = 0, pad_bad = 0, rstn_low = 0;
    int first_beat_cyc = 0, last_beat_cyc = 0, wait_cyc = 0;
    bit mute = 0, stray = 0, stray_load = 0;

    always @(negedge clk) begin
        div_data_vld_out = 1'b0;
        if (!div_rst_n) begin
            mphase = 0; mcnt = 0;
            if (!rst) rstn_low++;
        end else begin
            if (div_valid_in) begin starts++; mcnt = 0; mphase = 1; end
            if (div_data_vld_in) begin
                if (mcnt == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                mx = {mx[N-B-1:0], div_dividend_in};
                if (mcnt < MB) md = {md[M-B-1:0], div_divisor_in};
                else if (div_divisor_in != '0) pad_bad++;
                mcnt++; beats++;
                if (mcnt == NB) begin
                    wait_cyc = cyc;
                    mq = mx / {{(N-M){1'b0}}, md};
                    mlat = $urandom_range(1, 6); memit = 0; mphase = 2;
                end
            end
            if (mphase == 2 && !mute) begin
                if (mlat > 0) mlat--;
                else if (!skipped && $urandom_range(0, 3) == 0) skipped = 1;
                else begin
                    skipped = 0;
                    div_data_vld_out = 1'b1;
                    div_quotient_out = mq[memit*B +: B];
                    memit++;
                    if (memit == MB) mphase = 0;
                end
            end
            if (stray || (stray_load && mphase == 1 && mcnt == 5)) begin
                div_data_vld_out = 1'b1;
                div_quotient_out = {4{32'hdeadbeef}};
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_ops(input int r);
        for (int i = 0; i < N / 32; i++) lx[r][i*32 +: 32] = $urandom;
        for (int i = 0; i < M / 32; i++) ld[r][i*32 +: 32] = $urandom;
        ld[r][M-1] = 1'b1;
    endtask

    int rq;
    task automatic serve(input bit a0, input bit a1);
        logic [1:0] pend;
        pend = {a1, a0};
        req = pend; rq = cyc;
        for (int n = 0; n < 600 && pend != 2'b00; n++) begin
            tick(1);
            for (int r = 0; r < 2; r++)
                if (pend[r] && (done[r] || err[r])) begin pend[r] = 1'b0; req[r] = 1'b0; end
        end
        check("serve_complete", pend, 2'b00);
        req = 2'b00;
        tick(2);
    endtask

    task automatic check_q(input int r, input string tag);
        logic [N-1:0] e;
        e = lx[r] / {{(N-M){1'b0}}, ld[r]};
        for (int i = 0; i < MB; i++)
            check($sformatf("%s_q%0d", tag, i), qacc[r][i*B +: B], e[i*B +: B]);
        check({tag, "_nbeats"}, qcnt[r], MB);
        check({tag, "_done_beat"}, done_beat[r], MB);
    endtask

    int s_st, s_bt, s_pb, s_q, s_rl, s_er, s_dn;

    initial begin
        req = '0; rst = 1'b1;
        gap_at[0] = 99; gap_at[1] = 99; gap_len[0] = 0; gap_len[1] = 0;
        tick(3);
        check("rst_ctrl", {gnt, q_vld, done, err, div_valid_in, div_data_vld_in, div_rst_n}, 0);
        check("rst_bus", q_blk | div_dividend_in | div_divisor_in, 0);
        rst = 1'b0;
        tick(1);
        check("rstn_release", div_rst_n, 1);
        tick(2);

        // Single job: dividend = 7*d + 3, d = 2^2047 + 1
        ld[0] = '0; ld[0][M-1] = 1'b1; ld[0][0] = 1'b1;
        lx[0] = 7 * {{(N-M){1'b0}}, ld[0]} + 3;
        s_st = starts; s_bt = beats; s_pb = pad_bad;
        serve(1, 0);
        check("start_lat", gnt_rise[0] - rq, 1);
        check("first_beat_lat", first_beat_cyc - rq, 3);
        check("one_start", starts - s_st, 1);
        check("beats32", beats - s_bt, NB);
        check("divisor_pad", pad_bad - s_pb, 0);
        check("q7_blk0", qacc[0][B-1:0], 7);
        check("q7_upper_zero", {127'b0, |qacc[0][M-1:B]}, 0);
        check_q(0, "single");

        // Simultaneous pair after reset: lane 0 first
        rst = 1'b1; tick(2); rst = 1'b0; tick(2);
        rand_ops(0); rand_ops(1);
        serve(1, 1);
        check("pairA_order", done_cyc[0] < done_cyc[1], 1);
        check("pairA_regrant", gnt_rise[1] - done_cyc[0], 2);
        check_q(0, "pairA0"); check_q(1, "pairA1");

        // Operand gap of 3 cycles after beat 10
        rand_ops(0); gap_at[0] = 10; gap_len[0] = 3;
        s_bt = beats;
        serve(1, 0);
        check("gap_beats", beats - s_bt, NB);
        check("gap_len", (last_beat_cyc - first_beat_cyc + 1) - NB, 3);
        check_q(0, "gap");
        gap_at[0] = 99; gap_len[0] = 0;

        // Next simultaneous pair: lane 1 first
        rand_ops(0); rand_ops(1);
        serve(1, 1);
        check("pairB_order", done_cyc[1] < done_cyc[0], 1);
        check_q(0, "pairB0"); check_q(1, "pairB1");

        // Random single jobs with random operand gaps
        for (int k = 0; k < 3; k++) begin
            int r;
            r = $urandom_range(0, 1);
            rand_ops(r); gap_at[r] = $urandom_range(0, NB - 1); gap_len[r] = $urandom_range(0, 4);
            serve(r == 0, r == 1);
            check_q(r, $sformatf("rnd%0d", k));
            gap_at[r] = 99; gap_len[r] = 0;
        end

        // Stray quotient beat while idle
        s_q = qtotal;
        stray = 1; tick(1); stray = 0; tick(3);
        check("stray_idle", qtotal - s_q, 0);

        // Watchdog abort, with a stray beat injected during LOAD
        rand_ops(0); mute = 1; stray_load = 1;
        s_q = qtotal; s_rl = rstn_low; s_er = err_cnt[0]; s_dn = done_cnt[0];
        serve(1, 0);
        check("wd_err_pulse", err_cnt[0] - s_er, 1);
        check("wd_no_done", done_cnt[0] - s_dn, 0);
        check("wd_abort_time", err_cyc[0] - wait_cyc, TO);
        check("wd_div_rst_len", rstn_low - s_rl, 1);
        check("wd_gnt_release", gnt_fall[0] - err_cyc[0], 1);
        check("wd_no_qvld", qtotal - s_q, 0);
        mute = 0; stray_load = 0;

        // Reset in the middle of LOAD
        rand_ops(0); req = 2'b01;
        for (int n = 0; n < 200 && mcnt < 20; n++) tick(1);
        check("midrst_reached", mcnt >= 20, 1);
        rst = 1'b1; req = 2'b00;
        tick(1);
        check("midrst_ctrl", {gnt, q_vld, done, err, div_valid_in, div_data_vld_in, div_rst_n}, 0);
        check("midrst_bus", q_blk | div_dividend_in | div_divisor_in, 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        rand_ops(0); rand_ops(1);
        serve(1, 1);
        check("postrst_order", done_cyc[0] < done_cyc[1], 1);
        check_q(0, "postrst0"); check_q(1, "postrst1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
